// File: rtl/sound_pkg.sv
// Shared types and constants for the melody sequencer and its ROM.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        FINISH
    } snd_state_e;

    localparam logic [1:0] MEL_INTRO = 2'd0;
    localparam logic [1:0] MEL_EAT   = 2'd1;
    localparam logic [1:0] MEL_DEATH = 2'd2;
    localparam logic [1:0] MEL_WIN   = 2'd3;

    // Melodies that run the upstream tempo counter at 10x
    localparam logic [3:0] TURBO_MASK = 4'b0110;

    localparam int SND_NOTE_W = 4;

    typedef struct packed {
        logic                  last;
        logic [2:0]            dur;
        logic [SND_NOTE_W-1:0] note;
    } rom_entry_t;

    function automatic rom_entry_t ent(input logic l, input logic [2:0] d,
                                       input logic [SND_NOTE_W-1:0] n);
        ent = '{last: l, dur: d, note: n};
    endfunction

endpackage

// File: rtl/sound_melody_rom.sv
// Registered melody table addressed by {melody select, entry index}.
module sound_melody_rom
    import sound_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW+1:0] rd_addr,
    output rom_entry_t    rd_data
);

    logic [1:0]    sel;
    logic [AW-1:0] addr;
    rom_entry_t    entry;

    assign sel  = rd_addr[AW+1:AW];
    assign addr = rd_addr[AW-1:0];

    always_comb begin
        entry = ent(1'b1, 3'd0, '0);
        case (sel)
            MEL_INTRO: begin
                case (addr)
                    AW'(0):  entry = ent(1'b0, 3'd0, 4'd3);
                    AW'(1):  entry = ent(1'b0, 3'd1, 4'd1);
                    AW'(2):  entry = ent(1'b0, 3'd0, 4'd5);
                    AW'(3):  entry = ent(1'b0, 3'd0, 4'd0);
                    AW'(4):  entry = ent(1'b1, 3'd2, 4'd8);
                    default: entry = ent(1'b1, 3'd0, '0);
                endcase
            end
            MEL_EAT: begin
                case (addr)
                    AW'(0):  entry = ent(1'b0, 3'd0, 4'd5);
                    AW'(1):  entry = ent(1'b1, 3'd1, 4'd9);
                    default: entry = ent(1'b1, 3'd0, '0);
                endcase
            end
            MEL_DEATH: begin
                case (addr)
                    AW'(0):  entry = ent(1'b0, 3'd0, 4'd0);
                    AW'(1):  entry = ent(1'b0, 3'd2, 4'd7);
                    AW'(2):  entry = ent(1'b0, 3'd1, 4'd4);
                    AW'(3):  entry = ent(1'b1, 3'd3, 4'd2);
                    default: entry = ent(1'b1, 3'd0, '0);
                endcase
            end
            default: begin
                // Win fanfare never sets last: it runs to the end of the table
                entry = ent(1'b0, {2'b00, addr[0]}, SND_NOTE_W'(addr) + SND_NOTE_W'(1));
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_data <= '0;
        else       rd_data <= entry;
    end

endmodule

// File: rtl/sound_note_sequencer.sv
// Plays ROM melodies note by note, paced by the upstream tempo tick.
module sound_note_sequencer
    import sound_pkg::*;
#(
    parameter int MELODY_LEN = 16,
    parameter int NOTE_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              play_req,
    input  logic [1:0]        sound_sel,
    input  logic              stop_req,
    output logic [NOTE_W-1:0] note,
    output logic              sound_en,
    output logic              busy,
    output logic              done,
    output logic              turbo_req
);

    localparam int AW = (MELODY_LEN > 1) ? $clog2(MELODY_LEN) : 1;

    snd_state_e        state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [2:0]        dur_q, dur_d;
    logic              last_q, last_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              done_q, turbo_q;
    logic              preempt;
    rom_entry_t        rom_q;

    // ROM is addressed with the next-cycle pointer so its data is valid during LOAD
    sound_melody_rom #(.AW(AW)) u_rom (
        .clk     (clk),
        .reset   (reset),
        .rd_addr ({sel_d, addr_d}),
        .rd_data (rom_q)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        dur_d   = dur_q;
        last_d  = last_q;
        note_d  = note_q;
        preempt = play_req && (sound_sel > sel_q);
        case (state_q)
            IDLE: begin
                if (play_req) begin
                    state_d = LOAD;
                    sel_d   = sound_sel;
                    addr_d  = '0;
                end
            end
            LOAD: begin
                if (preempt) begin
                    sel_d  = sound_sel;
                    addr_d = '0;
                end else begin
                    state_d = PLAY;
                    note_d  = NOTE_W'(rom_q.note);
                    dur_d   = rom_q.dur;
                    last_d  = rom_q.last;
                end
            end
            PLAY: begin
                if (preempt) begin
                    state_d = LOAD;
                    sel_d   = sound_sel;
                    addr_d  = '0;
                end else if (tick) begin
                    if (dur_q != 3'd0) begin
                        dur_d = dur_q - 3'd1;
                    end else if (last_q || addr_q == AW'(MELODY_LEN - 1)) begin
                        state_d = FINISH;
                        note_d  = '0;
                    end else begin
                        state_d = LOAD;
                        addr_d  = addr_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything, including a same-cycle start request
        if (stop_req) begin
            state_d = IDLE;
            sel_d   = sel_q;
            addr_d  = addr_q;
            note_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            dur_q   <= '0;
            last_q  <= 1'b0;
            note_q  <= '0;
            done_q  <= 1'b0;
            turbo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            dur_q   <= dur_d;
            last_q  <= last_d;
            note_q  <= note_d;
            done_q  <= (state_d == FINISH);
            turbo_q <= (state_d != IDLE) && TURBO_MASK[sel_d];
        end
    end

    assign note      = note_q;
    assign busy      = (state_q != IDLE);
    assign sound_en  = (state_q == PLAY) && (note_q != '0);
    assign done      = done_q;
    assign turbo_req = turbo_q;

endmodule

// File: tb/tb_sound_note_sequencer.sv
// Directed scenarios plus random traffic, checked every cycle against a melody-walking model.
module tb_sound_note_sequencer;

    localparam int LEN = 16;

    logic       clk;
    logic       reset;
    logic       tick, play_req, stop_req;
    logic [1:0] sound_sel;
    logic [3:0] note;
    logic       sound_en, busy, done, turbo_req;

    int checks = 0;
    int errors = 0;
    int dones  = 0;
    bit chk_en = 0;

    sound_note_sequencer #(.MELODY_LEN(LEN), .NOTE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .play_req  (play_req),
        .sound_sel (sound_sel),
        .stop_req  (stop_req),
        .note      (note),
        .sound_en  (sound_en),
        .busy      (busy),
        .done      (done),
        .turbo_req (turbo_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Melody table as {last, dur[2:0], note[3:0]}
    function automatic logic [7:0] mel(input int s, input int i);
        logic [7:0] r;
        r = 8'h80;
        case (s)
            0: case (i)
                   0: r = {1'b0, 3'd0, 4'd3};
                   1: r = {1'b0, 3'd1, 4'd1};
                   2: r = {1'b0, 3'd0, 4'd5};
                   3: r = {1'b0, 3'd0, 4'd0};
                   4: r = {1'b1, 3'd2, 4'd8};
                   default: ;
               endcase
            1: case (i)
                   0: r = {1'b0, 3'd0, 4'd5};
                   1: r = {1'b1, 3'd1, 4'd9};
                   default: ;
               endcase
            2: case (i)
                   0: r = {1'b0, 3'd0, 4'd0};
                   1: r = {1'b0, 3'd2, 4'd7};
                   2: r = {1'b0, 3'd1, 4'd4};
                   3: r = {1'b1, 3'd3, 4'd2};
                   default: ;
               endcase
            default: r = {1'b0, 3'(i % 2), 4'((i + 1) % 16)};
        endcase
        return r;
    endfunction

    // phase: 0 silent, 1 fetching entry, 2 sounding, 3 finished pulse
    typedef struct packed {
        int         phase;
        int         sel;
        int         idx;
        int         ticks;
        int         dur;
        logic [3:0] note;
        bit         last;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(input mstate_t s, input bit tk_i, input bit pl,
                                           input int sl, input bit st);
        mstate_t    n;
        logic [7:0] e;
        n = s;
        if (st) begin
            n.phase = 0;
            n.note  = 4'd0;
            return n;
        end
        if (s.phase == 0) begin
            if (pl) begin
                n.sel = sl; n.idx = 0; n.phase = 1;
            end
        end else if ((s.phase == 1 || s.phase == 2) && pl && sl > s.sel) begin
            n.sel = sl; n.idx = 0; n.phase = 1;
        end else if (s.phase == 1) begin
            e = mel(s.sel, s.idx);
            n.note = e[3:0]; n.dur = int'(e[6:4]); n.last = e[7];
            n.ticks = 0; n.phase = 2;
        end else if (s.phase == 2) begin
            if (tk_i) begin
                n.ticks = s.ticks + 1;
                // a note has sounded for dur+1 ticks once the count exceeds dur
                if (n.ticks > s.dur) begin
                    if (s.last || s.idx == LEN - 1) begin
                        n.phase = 3; n.note = 4'd0;
                    end else begin
                        n.idx = s.idx + 1; n.phase = 1;
                    end
                end
            end
        end else begin
            n.phase = 0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= model_next(m, tick, play_req, int'(sound_sel), stop_req);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("note",      int'(note),      int'(m.note));
            chk("sound_en",  int'(sound_en),  int'(m.phase == 2 && m.note != 4'd0));
            chk("busy",      int'(busy),      int'(m.phase != 0));
            chk("done",      int'(done),      int'(m.phase == 3));
            chk("turbo_req", int'(turbo_req), int'(m.phase != 0 && (m.sel == 1 || m.sel == 2)));
        end
    end

    task automatic tk();
        @(negedge clk);
        if (done) dones++;
    endtask

    task automatic pulse_play(input int s);
        play_req = 1'b1; sound_sel = 2'(s);
        tk();
        play_req = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_req = 1'b1;
        tk();
        stop_req = 1'b0;
    endtask

    task automatic tick_after(input int gap);
        repeat (gap) tk();
        tick = 1'b1;
        tk();
        tick = 1'b0;
    endtask

    initial begin
        int d0;
        int guard;
        tick = 0; play_req = 0; stop_req = 0; sound_sel = 0; reset = 1'b1;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Idle after reset
        repeat (100) tk();
        chk("idle_note", int'(note), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_sound_en", int'(sound_en), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_turbo", int'(turbo_req), 0);

        // Eat melody at slow tempo
        d0 = dones;
        pulse_play(1);
        tk();
        chk("eat_note0", int'(note), 5);
        chk("eat_turbo", int'(turbo_req), 1);
        tick_after(18);
        tk();
        chk("eat_note1", int'(note), 9);
        tick_after(18);
        chk("eat_hold9", int'(note), 9);
        tick_after(18);
        chk("eat_done", int'(done), 1);
        chk("eat_busy_at_done", int'(busy), 1);
        tk();
        chk("eat_busy_after", int'(busy), 0);
        chk("eat_done_once", dones - d0, 1);

        // Priority: equal select ignored, higher select restarts
        pulse_play(0);
        tk();
        chk("intro_note0", int'(note), 3);
        pulse_play(0);
        chk("intro_ignored", int'(note), 3);
        pulse_play(3);
        tk();
        chk("win_note0", int'(note), 1);
        chk("win_turbo", int'(turbo_req), 0);
        pulse_stop();

        // Stop beats a simultaneous play
        pulse_play(0);
        tk();
        d0 = dones;
        stop_req = 1'b1; play_req = 1'b1; sound_sel = 2'd2;
        tk();
        stop_req = 1'b0; play_req = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_note", int'(note), 0);
        repeat (10) tk();
        chk("stop_no_done", dones - d0, 0);

        // Asynchronous reset mid-note
        pulse_play(1);
        tk();
        #2 reset = 1'b1;
        #1;
        chk("arst_note", int'(note), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_turbo", int'(turbo_req), 0);
        chk("arst_sound_en", int'(sound_en), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (5) tk();
        chk("arst_stays_idle", int'(busy), 0);
        pulse_play(2);
        tk();
        chk("death_rest_note", int'(note), 0);
        chk("death_rest_en", int'(sound_en), 0);
        chk("death_busy", int'(busy), 1);
        pulse_stop();

        // Win melody has no last flag: must stop after entry 15
        d0 = dones;
        guard = 0;
        pulse_play(3);
        while (busy && guard < 400) begin
            tick = (guard % 2 == 0);
            tk();
            guard++;
        end
        tick = 1'b0;
        chk("win_terminates", int'(guard < 400), 1);
        chk("win_done_once", dones - d0, 1);
        repeat (5) tk();
        chk("win_no_wrap", int'(busy), 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            tick      = ($urandom_range(2) == 0);
            play_req  = ($urandom_range(11) == 0);
            sound_sel = 2'($urandom_range(3));
            stop_req  = ($urandom_range(59) == 0);
            tk();
        end
        tick = 0; play_req = 0; stop_req = 0;
        repeat (5) tk();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
